// File: rtl/ocu_pkg.sv
// rtl/ocu_pkg.sv - shared types and helpers for the output compare unit
package ocu_pkg;

    localparam int OCU_MODE_W = 3;

    typedef enum logic [OCU_MODE_W-1:0] {
        OCU_OFF    = 3'd0,
        OCU_SET    = 3'd1,
        OCU_CLR    = 3'd2,
        OCU_TOGGLE = 3'd3,
        OCU_PWM    = 3'd4
    } ocu_mode_t;

    // Codes 5-7 are reserved and behave exactly like OFF.
    function automatic logic ocu_mode_live(input logic [OCU_MODE_W-1:0] m);
        return (m == OCU_SET) || (m == OCU_CLR) || (m == OCU_TOGGLE) || (m == OCU_PWM);
    endfunction

endpackage

// File: rtl/output_compare_unit_if.sv
// rtl/output_compare_unit_if.sv - register/pin bundle of the output compare unit
interface output_compare_unit_if #(
    parameter int CNT_W  = 16,
    parameter int NUM_CH = 4
);
    logic                    enable;
    logic [CNT_W-1:0]        counter_value;
    logic                    period_wrap;
    logic [NUM_CH-1:0]       match_wr;
    logic [CNT_W-1:0]        match_wdata;
    logic [NUM_CH*3-1:0]     ch_mode;
    logic [NUM_CH-1:0]       ch_pol;
    logic [NUM_CH-1:0]       intr_en;
    logic [NUM_CH-1:0]       flag_clr;
    logic [NUM_CH-1:0]       ch_out;
    logic [NUM_CH-1:0]       flag;
    logic [NUM_CH-1:0]       intr;
    logic                    intr_any;
    logic [NUM_CH*CNT_W-1:0] match_active;

    modport master (
        output enable, counter_value, period_wrap, match_wr, match_wdata,
               ch_mode, ch_pol, intr_en, flag_clr,
        input  ch_out, flag, intr, intr_any, match_active
    );

    modport slave (
        input  enable, counter_value, period_wrap, match_wr, match_wdata,
               ch_mode, ch_pol, intr_en, flag_clr,
        output ch_out, flag, intr, intr_any, match_active
    );
endinterface

// File: rtl/ocu_channel.sv
// rtl/ocu_channel.sv - one compare channel: double-buffered match, mode logic, sticky flag
module ocu_channel
    import ocu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [CNT_W-1:0]      counter_value,
    input  logic                  period_wrap,
    input  logic                  match_wr,
    input  logic [CNT_W-1:0]      match_wdata,
    input  logic [OCU_MODE_W-1:0] mode,
    input  logic                  flag_clr,
    output logic                  raw_out,
    output logic                  flag,
    output logic [CNT_W-1:0]      match_active
);

    logic [CNT_W-1:0] shadow_q;
    logic             pending_q;
    logic             evt;
    logic             raw_d;
    logic             flag_d;
    ocu_mode_t        mode_e;

    assign mode_e = ocu_mode_t'(mode);

    // Compare is combinational so the resulting update lands one edge later.
    always_comb begin
        evt = enable && ocu_mode_live(mode) && (counter_value == match_active);
    end

    // Next raw output; in PWM a match on the wrap cycle clears, giving 0% duty.
    always_comb begin
        raw_d = raw_out;
        if (evt) begin
            case (mode_e)
                OCU_SET:    raw_d = 1'b1;
                OCU_CLR:    raw_d = 1'b0;
                OCU_TOGGLE: raw_d = ~raw_out;
                OCU_PWM:    raw_d = 1'b0;
                default:    raw_d = raw_out;
            endcase
        end else if (enable && period_wrap && (mode_e == OCU_PWM)) begin
            raw_d = 1'b1;
        end
    end

    // Sticky flag: a match in the same cycle as a clear keeps the flag set.
    always_comb begin
        flag_d = flag;
        if (evt) begin
            flag_d = 1'b1;
        end else if (flag_clr) begin
            flag_d = 1'b0;
        end
    end

    // Raw output and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_out <= 1'b0;
            flag    <= 1'b0;
        end else begin
            raw_out <= raw_d;
            flag    <= flag_d;
        end
    end

    // Shadow/active match buffering; a write on the wrap cycle waits for the next wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q     <= '1;
            match_active <= '1;
            pending_q    <= 1'b0;
        end else begin
            if (period_wrap && pending_q) begin
                match_active <= shadow_q;
                pending_q    <= 1'b0;
            end
            if (match_wr) begin
                shadow_q  <= match_wdata;
                pending_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_compare_unit.sv
// rtl/output_compare_unit.sv - multi-channel output compare / PWM unit
module output_compare_unit
    import ocu_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int NUM_CH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    output_compare_unit_if.slave bus
);

    logic [NUM_CH-1:0]       raw_vec;
    logic [NUM_CH-1:0]       flag_vec;
    logic [NUM_CH-1:0]       intr_vec;
    logic [NUM_CH*CNT_W-1:0] active_vec;

    // One independent channel per compare output.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ocu_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .enable        (bus.enable),
            .counter_value (bus.counter_value),
            .period_wrap   (bus.period_wrap),
            .match_wr      (bus.match_wr[i]),
            .match_wdata   (bus.match_wdata),
            .mode          (bus.ch_mode[i*OCU_MODE_W +: OCU_MODE_W]),
            .flag_clr      (bus.flag_clr[i]),
            .raw_out       (raw_vec[i]),
            .flag          (flag_vec[i]),
            .match_active  (active_vec[i*CNT_W +: CNT_W])
        );
    end

    // Polarity and interrupt masking act after the flops, with no added latency.
    always_comb begin
        intr_vec = flag_vec & bus.intr_en;
    end

    assign bus.ch_out       = raw_vec ^ bus.ch_pol;
    assign bus.flag         = flag_vec;
    assign bus.intr         = intr_vec;
    assign bus.intr_any     = |intr_vec;
    assign bus.match_active = active_vec;

endmodule

// File: tb/tb_output_compare_unit.sv
// tb/tb_output_compare_unit.sv - scoreboard bench for output_compare_unit
module tb_output_compare_unit;

    localparam int CNT_W  = 16;
    localparam int NUM_CH = 4;

    typedef struct {
        logic [NUM_CH-1:0]       ch_out;
        logic [NUM_CH-1:0]       flag;
        logic [NUM_CH-1:0]       intr;
        logic                    intr_any;
        logic [NUM_CH*CNT_W-1:0] act;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    output_compare_unit_if #(.CNT_W(CNT_W), .NUM_CH(NUM_CH)) bus ();

    output_compare_unit #(.CNT_W(CNT_W), .NUM_CH(NUM_CH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // stimulus state
    bit                en;
    bit                wrap;
    bit                rst_v;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  period;
    logic [NUM_CH-1:0] wr;
    logic [CNT_W-1:0]  wdata;
    logic [NUM_CH-1:0] pol;
    logic [NUM_CH-1:0] ien;
    logic [NUM_CH-1:0] clr;
    int                mode_v [NUM_CH];

    // reference model state
    bit                m_raw    [NUM_CH];
    bit                m_flag   [NUM_CH];
    bit                m_pend   [NUM_CH];
    logic [CNT_W-1:0]  m_shadow [NUM_CH];
    logic [CNT_W-1:0]  m_active [NUM_CH];

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   stim_done = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    endtask

    // Apply the cycle's inputs, advance the model by one clock and queue what the DUT must show.
    task automatic drive_and_model();
        exp_t e;
        bit   fires;
        rst                   = rst_v;
        bus.enable            = en;
        bus.counter_value     = cnt;
        bus.period_wrap       = wrap;
        bus.match_wr          = wr;
        bus.match_wdata       = wdata;
        bus.ch_pol            = pol;
        bus.intr_en           = ien;
        bus.flag_clr          = clr;
        for (int i = 0; i < NUM_CH; i++) bus.ch_mode[i*3 +: 3] = mode_v[i][2:0];

        for (int i = 0; i < NUM_CH; i++) begin
            if (rst_v) begin
                m_raw[i] = 0; m_flag[i] = 0; m_pend[i] = 0;
                m_shadow[i] = '1; m_active[i] = '1;
            end else begin
                fires = en && (mode_v[i] >= 1) && (mode_v[i] <= 4) && (cnt == m_active[i]);
                if (fires) begin
                    if (mode_v[i] == 1)      m_raw[i] = 1;
                    else if (mode_v[i] == 3) m_raw[i] = !m_raw[i];
                    else                     m_raw[i] = 0;
                    m_flag[i] = 1;
                end else begin
                    if (en && wrap && mode_v[i] == 4) m_raw[i] = 1;
                    if (clr[i]) m_flag[i] = 0;
                end
                if (wrap && m_pend[i]) begin
                    m_active[i] = m_shadow[i];
                    m_pend[i]   = 0;
                end
                if (wr[i]) begin
                    m_shadow[i] = wdata;
                    m_pend[i]   = 1;
                end
            end
        end

        for (int i = 0; i < NUM_CH; i++) begin
            e.ch_out[i]             = m_raw[i] ^ pol[i];
            e.flag[i]               = m_flag[i];
            e.intr[i]               = m_flag[i] & ien[i];
            e.act[i*CNT_W +: CNT_W] = m_active[i];
        end
        e.intr_any = |e.intr;
        exp_q.push_back(e);
    endtask

    task automatic cycle();
        @(negedge clk);
        drive_and_model();
    endtask

    // Free-running counter that wraps to 0 after reaching period.
    task automatic tick();
        cnt  = (cnt >= period) ? '0 : cnt + 1'b1;
        wrap = (cnt == 0);
        cycle();
        wr  = '0;
        clr = '0;
    endtask

    task automatic run_until(input logic [CNT_W-1:0] stop_cnt);
        do tick(); while (cnt != stop_cnt);
    endtask

    task automatic write_match(input int ch, input logic [CNT_W-1:0] v);
        wr     = '0;
        wr[ch] = 1'b1;
        wdata  = v;
        tick();
    endtask

    // Monitor: compares every DUT output set just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ch_out",       64'(bus.ch_out),   64'(e.ch_out));
                check("flag",         64'(bus.flag),     64'(e.flag));
                check("intr",         64'(bus.intr),     64'(e.intr));
                check("intr_any",     64'(bus.intr_any), 64'(e.intr_any));
                check("match_active", 64'(bus.match_active), 64'(e.act));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        en = 1; wrap = 0; rst_v = 1; cnt = 16'h00FF; period = 16'h00FF;
        wr = '0; wdata = '0; pol = '0; ien = '0; clr = '0;
        foreach (mode_v[i]) mode_v[i] = 0;
        rst = 1'b1;
        drive_and_model();
        void'(exp_q.pop_front());
        cycle();
        cycle();
        rst_v = 0;

        // directed: SET, PWM, buffered writes, TOGGLE with clear collision
        mode_v[0] = 1; mode_v[1] = 4; mode_v[2] = 1; mode_v[3] = 3;
        ien = 4'b1000;
        write_match(0, 16'h0010);
        write_match(1, 16'h0040);
        write_match(3, 16'h0005);
        run_until(16'h0080);
        write_match(2, 16'h0020);
        run_until(16'h00FF);
        cnt = 16'h00FF;
        wr = 4'b0100; wdata = 16'h0030;
        tick();
        for (int p = 0; p < 3; p++) begin
            if (p == 2) pol[1] = 1'b1;
            do begin
                if (cnt == 16'h0004) clr[3] = 1'b1;
                tick();
            end while (cnt != 16'h00FF);
        end

        // PWM extremes: match at wrap count, then match beyond the period
        pol = '0;
        write_match(1, 16'h0000);
        run_until(16'h00FF);
        run_until(16'h00FF);
        write_match(1, 16'hFFFF);
        run_until(16'h00FF);
        run_until(16'h00FF);

        // reset in mid-period with a pending write and outputs high
        pol = 4'b0101;
        run_until(16'h0060);
        write_match(0, 16'h0003);
        rst_v = 1; cycle(); cycle(); rst_v = 0;
        run_until(16'h00FF);
        run_until(16'h0010);

        // randomized phase with a short period
        period = 16'h001F;
        cnt    = '0;
        for (int n = 0; n < 3000; n++) begin
            en = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < NUM_CH; i++) begin
                if ($urandom_range(0, 31) == 0) mode_v[i] = $urandom_range(0, 7);
                wr[i]  = ($urandom_range(0, 7) == 0);
                clr[i] = ($urandom_range(0, 7) == 0);
            end
            wdata = 16'($urandom_range(0, 16'h24));
            if ($urandom_range(0, 63) == 0) pol = 4'($urandom);
            if ($urandom_range(0, 31) == 0) ien = 4'($urandom);
            rst_v = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst_v = 0;
        stim_done = 1;

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d left expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
